// File: rtl/data_mem_responder.sv
// data_mem_responder: in-order load/store responder backed by a 64-bit word
// memory. Requests are queued in a small FIFO. A three-state FSM services the
// FIFO head after a fixed latency and holds each response until it is taken.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. A valid source keeps its payload stable until that edge. Ready never
// depends combinationally on the partner's valid.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 3,
    parameter int QDEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [$clog2(DEPTH_WORDS*8)-1:0] req_addr,
    input  logic [1:0]                       req_size,
    input  logic [63:0]                      req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [63:0]                      resp_rdata,
    output logic                             resp_write,
    output logic                             resp_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS * 8);
    localparam int WIDX_W = ADDR_W - 3;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LAT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [63:0]       wdata;
    } entry_t;

    // Storage and queue
    logic [63:0]      mem_q  [DEPTH_WORDS];
    entry_t           fifo_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Service FSM and response registers
    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [63:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_write_q, resp_write_d;
    logic             resp_err_q, resp_err_d;

    // Access datapath for the FIFO head
    entry_t            head;
    logic [WIDX_W-1:0] word_idx;
    logic [2:0]        byte_off;
    logic [5:0]        bit_off;
    logic [63:0]       size_mask;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic [63:0]       rd_word;
    logic [63:0]       load_data;
    logic [63:0]       wr_mask;
    logic [63:0]       wr_word;
    logic              mem_we;

    logic push;
    logic pop;

    // Readiness comes from the registered count only, and is forced low in reset
    assign req_ready  = !reset && (count_q < QDEPTH_C);
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == S_RESP) && resp_ready;

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_write = resp_write_q;
    assign resp_err   = resp_err_q;

    // Decode the head entry into word index, byte lane masks and merged store word
    always_comb begin
        head       = fifo_q[rd_ptr_q];
        word_idx   = head.addr[ADDR_W-1:3];
        byte_off   = head.addr[2:0];
        bit_off    = {byte_off, 3'b000};
        size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        align_mask = 3'b111;
        case (head.size)
            2'd0: begin size_mask = 64'h0000_0000_0000_00FF; align_mask = 3'b000; end
            2'd1: begin size_mask = 64'h0000_0000_0000_FFFF; align_mask = 3'b001; end
            2'd2: begin size_mask = 64'h0000_0000_FFFF_FFFF; align_mask = 3'b011; end
            default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; align_mask = 3'b111; end
        endcase
        misaligned = (byte_off & align_mask) != 3'b000;
        rd_word    = mem_q[word_idx];
        load_data  = (rd_word >> bit_off) & size_mask;
        wr_mask    = size_mask << bit_off;
        wr_word    = (rd_word & ~wr_mask) | ((head.wdata << bit_off) & wr_mask);
    end

    // FIFO occupancy and pointer bookkeeping
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Service FSM: wait out the latency, perform the access, hold the response
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        resp_rdata_d = resp_rdata_q;
        resp_write_d = resp_write_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    lat_d   = LAT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (lat_q == '0) begin
                    resp_write_d = head.write;
                    resp_err_d   = misaligned;
                    resp_rdata_d = (!head.write && !misaligned) ? load_data : 64'd0;
                    mem_we       = head.write && !misaligned;
                    state_d      = S_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (count_d != '0) begin
                        lat_d   = LAT_LOAD;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_q        <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            resp_rdata_q <= 64'd0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            resp_rdata_q <= resp_rdata_d;
            resp_write_q <= resp_write_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Capture accepted requests into the FIFO slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr,
                                  size: req_size, wdata: req_wdata};
        end
    end

    // Word memory is never cleared; an access landing on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[word_idx] <= wr_word;
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters: name, default, meaning. Each parameter SHALL have exactly the value and role on its line below.
- DEPTH_WORDS, 128: number of 64-bit storage words.
- LATENCY, 3: cycles from request acceptance to first resp_valid, minimum 2.
- QDEPTH, 4: request queue entries, power of 2.
REQ-002 Ports: name, direction, width, meaning. The block SHALL expose exactly the ports listed below.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  processor presents a load/store request.
- req_ready  out  1  queue can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  log2(DEPTH_WORDS*8)  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  processor accepts the response.
- resp_rdata  out  64  load data, zero-extended, or 0 for stores and errors.
- resp_write  out  1  echo of req_write for this response.
- resp_err  out  1  misaligned-access flag.

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1, and pushed into an in-order FIFO of QDEPTH entries.
REQ-004 req_ready SHALL be 1 iff the FIFO count is less than QDEPTH, based on the registered count only; a same-cycle pop SHALL NOT raise req_ready.
REQ-005 The service FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-006 In IDLE with the FIFO non-empty, the FSM SHALL load latency counter = LATENCY-2 and go to BUSY on the next edge.
REQ-007 In BUSY, the counter SHALL decrement each cycle; when it reaches 0, the FSM SHALL perform the access, register the response fields, and go to RESP.
REQ-008 In RESP, resp_valid SHALL be 1 and all resp_* outputs SHALL be held stable until an edge with resp_ready=1.
REQ-009 On the resp_ready=1 edge in RESP, the FSM SHALL pop the head entry and move to BUSY with the counter reloaded if another entry remains, or to IDLE otherwise.
REQ-010 Latency: a request accepted at edge T with the queue empty and the FSM in IDLE SHALL produce resp_valid=1 in the cycle following edge T+LATENCY.
REQ-011 Alignment: the low log2(2^req_size) address bits SHALL be 0; otherwise resp_err=1, resp_rdata=0, and memory SHALL NOT be modified.
REQ-012 Store: only the 2^req_size bytes at req_addr SHALL be written, little-endian from req_wdata[7:0] upward; resp_rdata SHALL be 0.
REQ-013 Load: resp_rdata SHALL hold the 2^req_size bytes at req_addr, little-endian, with upper bits 0.
REQ-014 Responses SHALL be returned strictly in acceptance order.
REQ-015 A load SHALL observe every store accepted before it.
REQ-016 Simultaneous push and pop SHALL leave the count unchanged with no data loss.
REQ-017 FIFO pointers SHALL wrap modulo QDEPTH.
REQ-018 resp_valid SHALL be 0 outside the RESP state.

Reset
REQ-019 When reset=1 at an edge, the block SHALL set FSM=IDLE, FIFO count=0, pointers=0, counter=0, resp_valid=0, resp_rdata=0, resp_write=0, resp_err=0.
REQ-020 While reset=1, req_ready SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.
REQ-021 Reset mid-operation SHALL discard all queued and in-flight requests without performing their memory writes; writes completed before reset SHALL persist, since storage is not cleared.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Dword store at addr 0x10, data 0x1122334455667788, then a dword load at 0x10: first response resp_write=1, rdata=0; second response rdata=0x1122334455667788, resp_err=0.
- Byte load at 0x13 after the store above: rdata=0x0000000000000055; half store 0xBEEF at 0x12, then dword load at 0x10: rdata=0x11223344BEEF7788.
- Word load at 0x0A: resp_err=1, rdata=0; a following dword load at 0x10 returns unchanged data.
- Single load accepted at edge T with LATENCY=3: resp_valid first high after edge T+3.
- Five back-to-back requests with resp_ready=0: req_ready drops after the 4th acceptance; raising resp_ready drains responses in order; the 5th request is accepted once a slot frees.
- Reset asserted while a store to 0x20 sits in BUSY: no response appears, and a subsequent load at 0x20 returns the pre-store value.
